// File: rtl/aes_sbox_arbiter.sv
// aes_sbox_arbiter: shares one 32-bit S-box word instance between the key
// expansion logic (key requester) and the encipher round datapath (enc
// requester). Grants are registered and use round-robin priority, a burst
// limit and a per-requester lock. The S-box result is routed back to its
// owner together with an ack. Results can come from a combinational S-box
// (SBOX_LATENCY=0) or from a registered S-box (SBOX_LATENCY=1).
module aes_sbox_arbiter #(
  parameter int MAX_BURST    = 4,
  parameter int SBOX_LATENCY = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        key_req,
  input  logic        key_lock,
  input  logic [31:0] key_sboxw,
  output logic        key_gnt,
  output logic        key_ack,
  output logic [31:0] key_new_sboxw,
  input  logic        enc_req,
  input  logic        enc_lock,
  input  logic [31:0] enc_sboxw,
  output logic        enc_gnt,
  output logic        enc_ack,
  output logic [31:0] enc_new_sboxw,
  output logic [31:0] sboxw,
  input  logic [31:0] new_sboxw,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_KEY = 2'd1,
    GNT_ENC = 2'd2
  } state_t;

  // Counter value at which a contended, unlocked holder must yield.
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  burst_ctr_r;
  logic        last_key_r;     // 1: key was served last, 0: enc was served last
  logic        key_gnt_r;
  logic        enc_gnt_r;
  logic        burst_last_s;
  logic        held_s;
  logic        key_ack_s;
  logic        enc_ack_s;

  assign burst_last_s = (burst_ctr_r == BURST_LAST);
  assign held_s       = (key_gnt_r & key_req) | (enc_gnt_r & enc_req);

  // Next-state decode: round-robin tie break from IDLE, burst yield, lock hold.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (key_req && enc_req) begin
          state_nxt_s = last_key_r ? GNT_ENC : GNT_KEY;
        end else if (key_req) begin
          state_nxt_s = GNT_KEY;
        end else if (enc_req) begin
          state_nxt_s = GNT_ENC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT_KEY: begin
        if (!key_req) begin
          state_nxt_s = enc_req ? GNT_ENC : IDLE;
        end else if (!key_lock && burst_last_s && enc_req) begin
          state_nxt_s = GNT_ENC;
        end else begin
          state_nxt_s = GNT_KEY;
        end
      end
      GNT_ENC: begin
        if (!enc_req) begin
          state_nxt_s = key_req ? GNT_KEY : IDLE;
        end else if (!enc_lock && burst_last_s && key_req) begin
          state_nxt_s = GNT_KEY;
        end else begin
          state_nxt_s = GNT_ENC;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state, registered grants, burst counter and round-robin history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      key_gnt_r   <= 1'b0;
      enc_gnt_r   <= 1'b0;
      burst_ctr_r <= 4'd0;
      last_key_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      key_gnt_r <= (state_nxt_s == GNT_KEY);
      enc_gnt_r <= (state_nxt_s == GNT_ENC);

      // Any change of owner (including leaving/entering IDLE) restarts the burst.
      if (state_nxt_s != state_r) begin
        burst_ctr_r <= 4'd0;
      end else if (held_s && !burst_last_s) begin
        burst_ctr_r <= burst_ctr_r + 4'd1;
      end else begin
        burst_ctr_r <= burst_ctr_r;
      end

      if ((state_nxt_s == GNT_KEY) && (state_r != GNT_KEY)) begin
        last_key_r <= 1'b1;
      end else if ((state_nxt_s == GNT_ENC) && (state_r != GNT_ENC)) begin
        last_key_r <= 1'b0;
      end else begin
        last_key_r <= last_key_r;
      end
    end
  end

  // Operand mux onto the shared S-box; zero while nobody owns it.
  always_comb begin
    sboxw = 32'h0000_0000;
    if (key_gnt_r) begin
      sboxw = key_sboxw;
    end else if (enc_gnt_r) begin
      sboxw = enc_sboxw;
    end else begin
      sboxw = 32'h0000_0000;
    end
  end

  generate
    if (SBOX_LATENCY == 0) begin : g_comb_sbox
      // Combinational S-box: the result belongs to the current owner.
      assign key_ack_s = key_gnt_r & key_req;
      assign enc_ack_s = enc_gnt_r & enc_req;
    end else begin : g_reg_sbox
      logic key_ack_r;
      logic enc_ack_r;

      // Registered S-box: the ack follows the owner of the previous cycle.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          key_ack_r <= 1'b0;
          enc_ack_r <= 1'b0;
        end else begin
          key_ack_r <= key_gnt_r & key_req;
          enc_ack_r <= enc_gnt_r & enc_req;
        end
      end

      assign key_ack_s = key_ack_r;
      assign enc_ack_s = enc_ack_r;
    end
  endgenerate

  assign key_gnt       = key_gnt_r;
  assign enc_gnt       = enc_gnt_r;
  assign key_ack       = key_ack_s;
  assign enc_ack       = enc_ack_s;
  assign key_new_sboxw = key_ack_s ? new_sboxw : 32'h0000_0000;
  assign enc_new_sboxw = enc_ack_s ? new_sboxw : 32'h0000_0000;
  assign busy          = key_gnt_r | enc_gnt_r;

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// tb_aes_sbox_arbiter: directed bench for aes_sbox_arbiter. Three instances
// share one stimulus: dut0 (MAX_BURST=4, combinational S-box), dut1
// (MAX_BURST=1, combinational S-box) and dut2 (MAX_BURST=4, registered S-box).
module tb_aes_sbox_arbiter;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  localparam logic [31:0] KW  = 32'h5353_5353;
  localparam logic [31:0] KR  = 32'heded_eded;
  localparam logic [31:0] EW  = 32'h0102_0304;
  localparam logic [31:0] ER  = 32'h7c77_7bf2;
  localparam logic [31:0] Z   = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic kr = 1'b0, kl = 1'b0, er = 1'b0, el = 1'b0;
  logic [31:0] kw = 32'h0, ew = 32'h0;

  logic kg0, eg0, ka0, ea0, busy0, kg1, eg1, ka1, ea1, busy1, kg2, eg2, ka2, ea2, busy2;
  logic [31:0] kn0, en0, sw0, nsb0, kn1, en1, sw1, nsb1, kn2, en2, sw2, nsb2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign nsb0 = sub_word(sw0);
  assign nsb1 = sub_word(sw1);
  always @(posedge clk) nsb2 <= sub_word(sw2);

  aes_sbox_arbiter #(.MAX_BURST(4), .SBOX_LATENCY(0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .key_req(kr), .key_lock(kl), .key_sboxw(kw), .key_gnt(kg0), .key_ack(ka0), .key_new_sboxw(kn0),
    .enc_req(er), .enc_lock(el), .enc_sboxw(ew), .enc_gnt(eg0), .enc_ack(ea0), .enc_new_sboxw(en0),
    .sboxw(sw0), .new_sboxw(nsb0), .busy(busy0));

  aes_sbox_arbiter #(.MAX_BURST(1), .SBOX_LATENCY(0)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .key_req(kr), .key_lock(kl), .key_sboxw(kw), .key_gnt(kg1), .key_ack(ka1), .key_new_sboxw(kn1),
    .enc_req(er), .enc_lock(el), .enc_sboxw(ew), .enc_gnt(eg1), .enc_ack(ea1), .enc_new_sboxw(en1),
    .sboxw(sw1), .new_sboxw(nsb1), .busy(busy1));

  aes_sbox_arbiter #(.MAX_BURST(4), .SBOX_LATENCY(1)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .key_req(kr), .key_lock(kl), .key_sboxw(kw), .key_gnt(kg2), .key_ack(ka2), .key_new_sboxw(kn2),
    .enc_req(er), .enc_lock(el), .enc_sboxw(ew), .enc_gnt(eg2), .enc_ack(ea2), .enc_new_sboxw(en2),
    .sboxw(sw2), .new_sboxw(nsb2), .busy(busy2));

  typedef struct {
    logic        kr, kl;
    logic [31:0] kw;
    logic        er, el;
    logic [31:0] ew;
    logic        xkg, xeg, xka, xea;
    logic [31:0] xkn, xen, xsw;
    logic        xbusy;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // dut0 outputs against one expected record
  task automatic chk_dut0(input string tag, input vec_t v);
    chk({tag, " key_gnt"}, 32'(kg0), 32'(v.xkg));
    chk({tag, " enc_gnt"}, 32'(eg0), 32'(v.xeg));
    chk({tag, " key_ack"}, 32'(ka0), 32'(v.xka));
    chk({tag, " enc_ack"}, 32'(ea0), 32'(v.xea));
    chk({tag, " key_new"}, kn0, v.xkn);
    chk({tag, " enc_new"}, en0, v.xen);
    chk({tag, " sboxw"},   sw0, v.xsw);
    chk({tag, " busy"},    32'(busy0), 32'(v.xbusy));
  endtask

  task automatic chk_idle0(input string tag);
    vec_t v;
    v = '{1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b0, 1'b0, 1'b0, 1'b0, Z, Z, Z, 1'b0};
    chk_dut0(tag, v);
  endtask

  initial begin
    // Fields: kr kl kw er el ew | kg eg ka ea key_new enc_new sboxw busy
    vecs[0]  = '{1'b1, 1'b0, 32'h0001_0203, 1'b0, 1'b0, Z,
                 1'b1, 1'b0, 1'b1, 1'b0, 32'h637c_777b, Z, 32'h0001_0203, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, Z, 1'b0, 1'b0, Z,
                 1'b0, 1'b0, 1'b0, 1'b0, Z, Z, Z, 1'b0};
    // key served last -> enc wins the tie out of IDLE, 4 cycles each after that
    for (int i = 2; i <= 5; i++)
      vecs[i] = '{1'b1, 1'b0, KW, 1'b1, 1'b0, EW, 1'b0, 1'b1, 1'b0, 1'b1, Z, ER, EW, 1'b1};
    for (int i = 6; i <= 9; i++)
      vecs[i] = '{1'b1, 1'b0, KW, 1'b1, 1'b0, EW, 1'b1, 1'b0, 1'b1, 1'b0, KR, Z, KW, 1'b1};
    vecs[10] = '{1'b1, 1'b0, KW, 1'b1, 1'b0, EW, 1'b0, 1'b1, 1'b0, 1'b1, Z, ER, EW, 1'b1};
    vecs[11] = '{1'b0, 1'b0, KW, 1'b1, 1'b0, EW, 1'b0, 1'b1, 1'b0, 1'b1, Z, ER, EW, 1'b1};
    // enc drops, key waiting -> direct handover without an IDLE cycle
    vecs[12] = '{1'b1, 1'b0, KW, 1'b0, 1'b0, EW, 1'b1, 1'b0, 1'b1, 1'b0, KR, Z, KW, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_idle0("reset");
    chk("reset dut2 key_ack", 32'(ka2), 32'd0);
    chk("reset dut2 enc_ack", 32'(ea2), 32'd0);
    reset_n = 1'b1;

    // Table-driven vectors on dut0
    for (int i = 0; i < 13; i++) begin
      kr = vecs[i].kr; kl = vecs[i].kl; kw = vecs[i].kw;
      er = vecs[i].er; el = vecs[i].el; ew = vecs[i].ew;
      @(posedge clk);
      #1;
      chk_dut0($sformatf("v%0d", i), vecs[i]);
    end

    // Grant still held but req already low: no ack, no result
    kr = 1'b0; er = 1'b0;
    #1;
    chk("holdlow key_gnt", 32'(kg0), 32'd1);
    chk("holdlow key_ack", 32'(ka0), 32'd0);
    chk("holdlow key_new", kn0, Z);
    @(posedge clk);
    #1;
    chk_idle0("holdlow idle");

    // Lock: enc keeps the S-box for 10 cycles while key waits
    kr = 1'b1; er = 1'b1; el = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("lock c%0d enc_gnt", c), 32'(eg0), 32'd1);
      chk($sformatf("lock c%0d key_gnt", c), 32'(kg0), 32'd0);
    end
    er = 1'b0; el = 1'b0;
    @(posedge clk);
    #1;
    chk("unlock key_gnt", 32'(kg0), 32'd1);
    chk("unlock enc_gnt", 32'(eg0), 32'd0);

    // Reset pulse, then both requesters rise together
    kr = 1'b0; er = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk_idle0("rst2");
    chk("rst2 dut1 busy", 32'(busy1), 32'd0);
    chk("rst2 dut2 busy", 32'(busy2), 32'd0);
    kr = 1'b1; er = 1'b1; kw = KW; ew = EW;
    reset_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      // MAX_BURST=4, combinational S-box
      chk($sformatf("cont c%0d dut0 key_gnt", c), 32'(kg0), 32'(c <= 4));
      chk($sformatf("cont c%0d dut0 enc_gnt", c), 32'(eg0), 32'(c > 4));
      chk($sformatf("cont c%0d dut0 sboxw", c), sw0, (c <= 4) ? KW : EW);
      // MAX_BURST=1 alternates every cycle, key first
      chk($sformatf("alt c%0d dut1 key_gnt", c), 32'(kg1), 32'(c % 2));
      chk($sformatf("alt c%0d dut1 enc_gnt", c), 32'(eg1), 32'(1 - (c % 2)));
      chk($sformatf("alt c%0d dut1 busy", c), 32'(busy1), 32'd1);
      // Registered S-box: acks trail the grant by one cycle
      chk($sformatf("lat1 c%0d key_gnt", c), 32'(kg2), 32'(c <= 4));
      chk($sformatf("lat1 c%0d enc_gnt", c), 32'(eg2), 32'(c > 4));
      chk($sformatf("lat1 c%0d key_ack", c), 32'(ka2), 32'(c >= 2 && c <= 5));
      chk($sformatf("lat1 c%0d enc_ack", c), 32'(ea2), 32'(c == 6));
      chk($sformatf("lat1 c%0d key_new", c), kn2, (c >= 2 && c <= 5) ? KR : Z);
      chk($sformatf("lat1 c%0d enc_new", c), en2, (c == 6) ? ER : Z);
    end

    // Asynchronous reset mid-burst: outputs drop before the next edge
    reset_n = 1'b0;
    #1;
    chk_idle0("async");
    chk("async dut2 enc_ack", 32'(ea2), 32'd0);
    chk("async dut2 enc_new", en2, Z);
    chk("async dut1 busy", 32'(busy1), 32'd0);
    #1;
    reset_n = 1'b1;
    kr = 1'b0; er = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset enc_gnt", 32'(eg0), 32'd1);
    chk("post-reset key_gnt", 32'(kg0), 32'd0);
    chk("post-reset enc_new", en0, ER);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
